systolic_mm_engine: RTL and testbench
=====================================

# systolic_mm_engine

Parametrised N×N signed matrix-multiply engine: two internal operand RAMs (A, B), a skewed-feed sequencer driving an N×N output-stationary PE grid, and a row-serial result port with valid/ready backpressure. It computes C = A·B, or C += A·B in accumulate mode. It replaces the fixed 4×4 array-plus-memory wrapper and sits between the host load path and the result write-back logic.

## Interface
- N, 4: array dimension, N ≥ 2; AAW = clog2(N*N), RW = clog2(N).
- DW, 16: signed operand width.
- ACCW, 2*DW+clog2(N) (34 at defaults): signed accumulator and result element width.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_a_en / wr_b_en  in  1  write strobe for the A or B RAM.
- wr_a_addr / wr_b_addr  in  AAW  word address = row*N + col.
- wr_a_data / wr_b_data  in  DW  signed operand word.
- start  in  1  launch request; sampled only in IDLE.
- acc  in  1  sampled with start: 0 clears accumulators, 1 keeps them.
- abort  in  1  cancels any busy operation.
- busy  out  1  high in FEED, FLUSH and DRAIN.
- done  out  1  one-cycle pulse after the final row is accepted.
- wr_err  out  1  one-cycle pulse when a write arrives while busy.
- out_valid  out  1  result row is available.
- out_ready  in  1  downstream accepts the row.
- out_row  out  RW  index of the presented row.
- out_data  out  N*ACCW  row elements; C[r][j] is at [j*ACCW +: ACCW].

## Operation
- States: IDLE, FEED, FLUSH, DRAIN.
- IDLE→FEED when start=1. If acc=0, all PE accumulators clear on entry.
- FEED lasts N cycles, k = 0..N-1. Each cycle reads column k of A and row k of B (registered read, 1-cycle latency).
- Row i of A is delayed i cycles on entry. Column j of B is delayed j cycles.
- Each PE passes a right and b down with one register each. A valid bit travels with the data, and a PE accumulates only when valid is set.
- FEED→FLUSH after k = N-1. FLUSH lasts 2N-1 cycles, then DRAIN.
- DRAIN presents rows r = 0..N-1, one beat per handshake (out_valid && out_ready). After row N-1 is accepted: go to IDLE and pulse done.
- Arithmetic: full-precision signed product, sign-extended to ACCW. Accumulation wraps modulo 2^ACCW.
- Writes:
  - Accepted only when busy=0.
  - A write in the same cycle as an accepted start lands before the first read.
  - While busy, writes are dropped and wr_err pulses.
- start while busy is ignored.
- abort while busy:
  - Next state is IDLE; out_valid drops; accumulators clear; no done pulse.
  - If abort coincides with a DRAIN handshake, that beat counts as transferred, but done is still suppressed.
  - abort in IDLE has no effect.
- Reset:
  - Returns the FSM to IDLE and zeroes accumulators, skew/valid registers and all outputs.
  - RAM contents are not reset and are unaffected by reset, including reset mid-operation.

## Timing
- Reset values: busy=0, done=0, wr_err=0, out_valid=0, out_row=0, out_data=0.
- start sampled at edge 0: busy=1 from cycle 1; FEED is cycles 1..N; FLUSH is cycles N+1..3N-1.
- out_valid=1 with row 0 from cycle 3N (cycle 12 at N=4).
- Last product into PE(N-1,N-1) is registered by cycle 3N.
- Under out_ready=1 throughout:
  - rows appear in cycles 3N..4N-1;
  - done pulses in cycle 4N with busy=0;
  - a new start is accepted in cycle 4N.
- While out_valid && !out_ready, out_data and out_row hold stable.
- out_data is registered from the accumulators by row mux. No combinational path from out_ready to out_valid.

## Structure
- Package mm_pkg holds:
  - the state encoding enum (IDLE/FEED/FLUSH/DRAIN);
  - default N, DW;
  - ACCW and AAW/RW derivation functions.
- Sub-module mm_pe: one PE with a/b/valid pass-through registers, a clear input and an ACCW accumulator; instantiated N×N via generate.
- The RAMs are inferred inline as N*N×DW arrays with synchronous read.

## Test plan
- A = identity, B[r][c] = 4r+c (N=4), acc=0 → rows read {0,1,2,3}, {4,5,6,7}, …; out_valid first at cycle 12; done at cycle 16.
- All A and B elements = -32768 → every C element = 2^32, exact, no wrap at ACCW=34.
- Run with acc=0, then re-run with acc=1 on the same data → second result = 2× first; a third run with acc=0 → 1× again.
- out_ready low for 5 cycles on row 1 → out_data/out_row stable; rows delivered in order 0..3; done after row 3 accepted.
- wr_a_en during FLUSH → wr_err pulse, RAM unchanged (verified by the next result); start during DRAIN ignored.
- abort in FLUSH cycle 2 → IDLE next cycle, no done, no out_valid; a following start with acc=1 yields a plain A·B (accumulators were cleared). Reset asserted mid-DRAIN → all outputs 0 immediately.

Source files
------------

// File: rtl/mm_pkg.sv
// mm_pkg: state encoding, default sizes and width helpers shared by the
// systolic matrix-multiply engine and its PEs.
package mm_pkg;
  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_e;
  localparam int DEF_N = 4;
  localparam int DEF_DW = 16;
  function automatic int acc_w(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction
  function automatic int addr_w(input int n);
    return $clog2(n * n);
  endfunction
  function automatic int row_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/mm_pe.sv
// mm_pe: output-stationary PE; forwards a right and b down one register each
// and accumulates the sign-extended product while the travelling valid is set.
module mm_pe #(
  parameter int DW = 16,
  parameter int ACCW = 34
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   v_in,
  input  logic signed [DW-1:0]   a_in,
  input  logic signed [DW-1:0]   b_in,
  output logic                   v_out,
  output logic signed [DW-1:0]   a_out,
  output logic signed [DW-1:0]   b_out,
  output logic signed [ACCW-1:0] acc
);
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] acc_d, acc_q;
  logic v_q;
  logic signed [DW-1:0] a_q, b_q;
  assign prod = a_in * b_in;
  always_comb acc_d = clr ? '0 : v_in ? acc_q + {{(ACCW-2*DW){prod[2*DW-1]}}, prod} : acc_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc_q <= '0;
      v_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      acc_q <= acc_d;
      v_q <= v_in && !clr;
      a_q <= a_in;
      b_q <= b_in;
    end
  assign v_out = v_q;
  assign a_out = a_q;
  assign b_out = b_q;
  assign acc = acc_q;
endmodule

// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine: N x N signed C = A*B (or C += A*B) engine with inline
// operand RAMs, skewed feed into an output-stationary PE grid and a row-serial result port.
module systolic_mm_engine
  import mm_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int DW = DEF_DW,
  localparam int ACCW = acc_w(N, DW),
  localparam int AAW = addr_w(N),
  localparam int RW = row_w(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_a_en,
  input  logic [AAW-1:0]       wr_a_addr,
  input  logic signed [DW-1:0] wr_a_data,
  input  logic                 wr_b_en,
  input  logic [AAW-1:0]       wr_b_addr,
  input  logic signed [DW-1:0] wr_b_data,
  input  logic                 start,
  input  logic                 acc,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 wr_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RW-1:0]        out_row,
  output logic [N*ACCW-1:0]    out_data
);
  localparam int CW = $clog2(2 * N);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] out_row_q, out_row_d, sel;
  logic out_valid_q, out_valid_d, done_q, done_d, wr_err_q, wr_err_d;
  logic [N*ACCW-1:0] out_data_q, out_data_d, row_sel;
  logic flush, clr, hs, rd_v_q;
  logic signed [DW-1:0] ram_a [N*N];
  logic signed [DW-1:0] ram_b [N*N];
  logic signed [DW-1:0] a_rd_q [N];
  logic signed [DW-1:0] b_rd_q [N];
  logic signed [DW-1:0] a_row [N];
  logic signed [DW-1:0] b_col [N];
  logic v_row [N];
  logic signed [DW-1:0] a_o [N][N];
  logic signed [DW-1:0] b_o [N][N];
  logic v_o [N][N];
  logic signed [ACCW-1:0] acc_o [N][N];
  assign busy = state_q != IDLE;
  assign flush = busy && abort;
  assign clr = flush || (state_q == IDLE && start && !acc);
  assign hs = out_valid_q && out_ready;
  always_ff @(posedge clk) begin
    if (wr_a_en && !busy) ram_a[wr_a_addr] <= wr_a_data;
    if (wr_b_en && !busy) ram_b[wr_b_addr] <= wr_b_data;
  end
  // column cnt of A and row cnt of B, one registered read per element
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_v_q <= 1'b0;
      a_rd_q <= '{default: '0};
      b_rd_q <= '{default: '0};
    end else begin
      rd_v_q <= state_q == FEED && !flush;
      if (state_q == FEED)
        for (int i = 0; i < N; i++) begin
          a_rd_q[i] <= ram_a[AAW'(i * N) + AAW'(cnt_q)];
          b_rd_q[i] <= ram_b[AAW'(cnt_q) * AAW'(N) + AAW'(i)];
        end
    end
  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_row[0] = a_rd_q[0];
      assign b_col[0] = b_rd_q[0];
      assign v_row[0] = rd_v_q;
    end else begin : g_delay
      logic signed [DW-1:0] a_q [i];
      logic signed [DW-1:0] b_q [i];
      logic v_q [i];
      always_ff @(posedge clk or negedge rst)
        if (!rst) begin
          a_q <= '{default: '0};
          b_q <= '{default: '0};
          v_q <= '{default: 1'b0};
        end else begin
          a_q[0] <= a_rd_q[i];
          b_q[0] <= b_rd_q[i];
          v_q[0] <= rd_v_q && !flush;
          for (int s = 1; s < i; s++) begin
            a_q[s] <= a_q[s-1];
            b_q[s] <= b_q[s-1];
            v_q[s] <= v_q[s-1] && !flush;
          end
        end
      assign a_row[i] = a_q[i-1];
      assign b_col[i] = b_q[i-1];
      assign v_row[i] = v_q[i-1];
    end
  end
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [DW-1:0] a_in, b_in;
      logic v_in;
      if (j == 0) begin : g_left
        assign a_in = a_row[i];
        assign v_in = v_row[i];
      end else begin : g_inner
        assign a_in = a_o[i][j-1];
        assign v_in = v_o[i][j-1];
      end
      if (i == 0) begin : g_top
        assign b_in = b_col[j];
      end else begin : g_below
        assign b_in = b_o[i-1][j];
      end
      mm_pe #(.DW(DW), .ACCW(ACCW)) u_pe (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .v_in(v_in),
        .a_in(a_in),
        .b_in(b_in),
        .v_out(v_o[i][j]),
        .a_out(a_o[i][j]),
        .b_out(b_o[i][j]),
        .acc(acc_o[i][j])
      );
    end
  end
  always_comb begin
    sel = state_q == FLUSH ? '0 : out_row_q + 1'b1;
    row_sel = '0;
    for (int j = 0; j < N; j++) row_sel[j*ACCW +: ACCW] = acc_o[sel][j];
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    out_row_d = out_row_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    done_d = 1'b0;
    wr_err_d = busy && (wr_a_en || wr_b_en);
    if (flush) begin
      state_d = IDLE;
      out_valid_d = 1'b0;
      out_row_d = '0;
      out_data_d = '0;
    end else
      case (state_q)
        IDLE: if (start) begin
          state_d = FEED;
          cnt_d = '0;
        end
        FEED: begin
          cnt_d = cnt_q == CW'(N - 1) ? '0 : cnt_q + 1'b1;
          state_d = cnt_q == CW'(N - 1) ? FLUSH : FEED;
        end
        FLUSH: if (cnt_q == CW'(2 * N - 2)) begin
          state_d = DRAIN;
          out_valid_d = 1'b1;
          out_row_d = '0;
          out_data_d = row_sel;
        end else cnt_d = cnt_q + 1'b1;
        DRAIN: if (hs) begin
          if (out_row_q == RW'(N - 1)) begin
            state_d = IDLE;
            out_valid_d = 1'b0;
            out_row_d = '0;
            out_data_d = '0;
            done_d = 1'b1;
          end else begin
            out_row_d = out_row_q + 1'b1;
            out_data_d = row_sel;
          end
        end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      out_row_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      done_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      out_row_q <= out_row_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      done_q <= done_d;
      wr_err_q <= wr_err_d;
    end
  assign done = done_q;
  assign wr_err = wr_err_q;
  assign out_valid = out_valid_q;
  assign out_row = out_row_q;
  assign out_data = out_data_q;
endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb_systolic_mm_engine: directed and random runs of the matrix engine checked
// against a plain-arithmetic matrix model with immediate assertions.
module tb_systolic_mm_engine;
  localparam int N = 4;
  localparam int DW = 16;
  localparam int ACCW = 34;
  localparam int AAW = 4;
  localparam int RW = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_a_en = 1'b0, wr_b_en = 1'b0;
  logic [AAW-1:0] wr_a_addr = '0, wr_b_addr = '0;
  logic signed [DW-1:0] wr_a_data = '0, wr_b_data = '0;
  logic start = 1'b0, acc = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic busy, done, wr_err, out_valid;
  logic [RW-1:0] out_row;
  logic [N*ACCW-1:0] out_data;
  int total = 0;
  int bad = 0;
  int ma [N][N];
  int mb [N][N];
  logic signed [ACCW-1:0] mc [N][N];
  always #5 clk = ~clk;
  systolic_mm_engine #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .wr_a_en(wr_a_en), .wr_a_addr(wr_a_addr), .wr_a_data(wr_a_data),
    .wr_b_en(wr_b_en), .wr_b_addr(wr_b_addr), .wr_b_data(wr_b_data),
    .start(start), .acc(acc), .abort(abort),
    .busy(busy), .done(done), .wr_err(wr_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_data(out_data)
  );
  task automatic chk(input string tag, input logic [N*ACCW-1:0] got, input logic [N*ACCW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wr(input int r, input int c, input logic signed [DW-1:0] av, input logic signed [DW-1:0] bv);
    wr_a_en = 1'b1;
    wr_b_en = 1'b1;
    wr_a_addr = AAW'(r * N + c);
    wr_b_addr = AAW'(r * N + c);
    wr_a_data = av;
    wr_b_data = bv;
    ma[r][c] = int'(av);
    mb[r][c] = int'(bv);
    @(negedge clk);
    wr_a_en = 1'b0;
    wr_b_en = 1'b0;
  endtask
  // mode 0: A = I, B[r][c] = 4r+c; mode 1: all -32768; mode 2: random
  task automatic load(input int mode);
    logic signed [DW-1:0] av, bv;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        av = mode == 0 ? DW'(r == c) : mode == 1 ? 16'sh8000 : DW'($urandom);
        bv = mode == 0 ? DW'(4 * r + c) : mode == 1 ? 16'sh8000 : DW'($urandom);
        wr(r, c, av, bv);
      end
  endtask
  task automatic model(input bit accm);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (!accm) mc[i][j] = '0;
        for (int k = 0; k < N; k++)
          mc[i][j] = mc[i][j] + ACCW'(longint'(ma[i][k]) * longint'(mb[k][j]));
      end
  endtask
  task automatic clear_model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mc[i][j] = '0;
  endtask
  function automatic logic [N*ACCW-1:0] exp_row(input int r);
    logic [N*ACCW-1:0] v;
    for (int j = 0; j < N; j++) v[j*ACCW +: ACCW] = mc[r][j];
    return v;
  endfunction
  task automatic do_run(input bit accm, input int stall_row, input bit timed,
                        input bit wr_flush, input bit start_drain, input bit late_wr);
    int e;
    logic signed [DW-1:0] lv;
    start = 1'b1;
    acc = accm;
    if (late_wr) begin
      lv = DW'($urandom);
      wr_a_en = 1'b1;
      wr_a_addr = '0;
      wr_a_data = lv;
      ma[0][0] = int'(lv);
    end
    model(accm);
    @(negedge clk);
    start = 1'b0;
    acc = 1'b0;
    wr_a_en = 1'b0;
    e = 1;
    chk("busy_after_start", busy, 1);
    while (!out_valid && e < 200) begin
      wr_a_en = wr_flush && e == N + 2;
      wr_a_addr = '0;
      wr_a_data = 16'sh7777;
      @(negedge clk);
      e++;
      wr_a_en = 1'b0;
      if (wr_flush && e == N + 3) chk("wr_err_pulse", wr_err, 1);
      if (wr_flush && e == N + 4) chk("wr_err_clear", wr_err, 0);
    end
    chk("valid_rise", out_valid, 1);
    if (timed) chk("valid_cycle", e, 3 * N);
    for (int r = 0; r < N; r++) begin
      chk("row_idx", out_row, r);
      chk("row_data", out_data, exp_row(r));
      if (r == stall_row) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          e++;
          chk("stall_valid", out_valid, 1);
          chk("stall_row", out_row, r);
          chk("stall_data", out_data, exp_row(r));
        end
        out_ready = 1'b1;
      end
      start = start_drain && r == 1;
      @(negedge clk);
      e++;
      start = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("idle_at_done", busy, 0);
    chk("valid_low", out_valid, 0);
    if (timed) chk("done_cycle", e, 4 * N);
    if (start_drain) begin
      @(negedge clk);
      chk("start_ignored", busy, 0);
      chk("done_single", done, 0);
    end
  endtask
  initial begin
    int g;
    logic seen;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_row", out_row, 0);
    chk("rst_data", out_data, 0);
    rst = 1'b1;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort", busy, 0);
    // identity, then accumulate twice-over, then plain again; back-to-back starts
    load(0);
    do_run(0, -1, 1, 0, 0, 0);
    do_run(1, -1, 1, 0, 0, 0);
    do_run(0, -1, 1, 0, 0, 0);
    load(2);
    do_run(0, 1, 0, 0, 0, 1);
    load(1);
    do_run(0, -1, 1, 0, 0, 0);
    load(2);
    do_run(0, -1, 0, 1, 1, 0);
    // abort in the second FLUSH cycle
    load(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (N + 1) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_done", done, 0);
    seen = 1'b0;
    repeat (4 * N) begin
      @(negedge clk);
      seen = seen | out_valid | done | busy;
    end
    chk("abort_quiet", seen, 0);
    clear_model();
    do_run(1, -1, 1, 0, 0, 0);
    // reset in the middle of DRAIN
    load(2);
    start = 1'b1;
    model(0);
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (!out_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain_reached", out_valid, 1);
    @(negedge clk);
    chk("row1_before_rst", out_row, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_wr_err", wr_err, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_row", out_row, 0);
    chk("mid_rst_data", out_data, 0);
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    @(negedge clk);
    do_run(1, -1, 1, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
